// File: rtl/d_lockout_timer.sv
// Entry-window / lockout timer: prescaled countdown, thermometer LED bar, RGB status.
// Define LOCK_ESCALATE_EN to double each consecutive lockout up to BASE_LOCK<<MAX_SHIFT.
module d_lockout_timer #(
  parameter int TICK_CYCLES = 125000000,
  parameter int LED_W       = 10,
  parameter int ERR_W       = 3,
  parameter int MAX_ERR     = 3,
  parameter int INPUT_WIN   = 10,
  parameter int BASE_LOCK   = 10,
  parameter int MAX_SHIFT   = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enb_cnt,
  input  logic             disable_cnt,
  input  logic             ignore,
  input  logic             clr_level,
  input  logic [ERR_W-1:0] error_counter,
  output logic             enb_inp,
  output logic             lock_active,
  output logic             timeout,
  output logic [LED_W-1:0] led_cnt,
  output logic [2:0]       rgb_out,
  output logic [2:0]       state
);
  localparam int LOCK_MAX = BASE_LOCK << MAX_SHIFT;
  localparam int REM_MAX  = (INPUT_WIN > LOCK_MAX) ? INPUT_WIN : LOCK_MAX;
  localparam int RW       = $clog2(REM_MAX + 1);
  localparam int PW       = $clog2(TICK_CYCLES);

  typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, LOCKOUT = 3'd2} state_t;

  state_t        st;
  logic [RW-1:0] remaining;
  logic [PW-1:0] presc;
  logic [RW-1:0] lock_len;
  logic          counting;
  logic          presc_end;
  logic          tick;

`ifdef LOCK_ESCALATE_EN
  localparam int LW = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1;
  logic [LW-1:0] level;
  assign lock_len = RW'(BASE_LOCK) << level;
`else
  logic unused_clr;
  assign unused_clr = clr_level;
  assign lock_len   = RW'(BASE_LOCK);
`endif

  assign counting  = (st == ENTRY) || (st == LOCKOUT);
  assign presc_end = (presc == PW'(TICK_CYCLES - 1));
  assign tick      = counting && !ignore && presc_end;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      remaining <= '0;
      presc     <= '0;
      timeout   <= 1'b0;
`ifdef LOCK_ESCALATE_EN
      level     <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      // prescaler free-runs while counting; any state change below re-zeroes it
      if (counting && !ignore) presc <= presc_end ? '0 : presc + 1'b1;
      case (st)
        IDLE: begin
          presc <= '0;
`ifdef LOCK_ESCALATE_EN
          if (clr_level) level <= '0;
`endif
          if (enb_cnt) begin
            st        <= ENTRY;
            remaining <= RW'(INPUT_WIN);
          end
        end
        ENTRY: begin
          if (error_counter >= ERR_W'(MAX_ERR)) begin
            st        <= LOCKOUT;
            remaining <= lock_len;
            presc     <= '0;
`ifdef LOCK_ESCALATE_EN
            if (level != LW'(MAX_SHIFT)) level <= level + 1'b1;
`endif
          end else if (disable_cnt) begin
            st    <= IDLE;
            presc <= '0;
`ifdef LOCK_ESCALATE_EN
            level <= '0;
`endif
          end else if (tick) begin
            if (remaining == RW'(1)) begin
              st      <= IDLE;
              presc   <= '0;
              timeout <= 1'b1;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end
        LOCKOUT: begin
          if (tick) begin
            if (remaining == RW'(1)) begin
              st    <= IDLE;
              presc <= '0;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end
        default: begin
          st    <= IDLE;
          presc <= '0;
        end
      endcase
    end
  end

  assign state       = st;
  assign enb_inp     = (st == ENTRY);
  assign lock_active = (st == LOCKOUT);

  always_comb begin
    rgb_out = 3'b001;
    case (st)
      ENTRY:   rgb_out = 3'b010;
      LOCKOUT: rgb_out = (presc < PW'(TICK_CYCLES / 2)) ? 3'b100 : 3'b000;
      default: rgb_out = 3'b001;
    endcase
  end

  // thermometer: bit i lit while more than i ticks remain
  for (genvar i = 0; i < LED_W; i++) begin : g_led
    assign led_cnt[i] = counting && (32'(remaining) > 32'(i));
  end
endmodule
